stall_controller: RTL and testbench
===================================

STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 The block SHALL have parameter FLUSH_LEN, default 2, giving total flush cycles per taken branch (legal 1..15).
REQ-002 The block SHALL have parameter WDOG_MAX, default 255, giving the consecutive hazard-stall cycle count that raises the timeout (legal 1..255).
REQ-003 Port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port i_stall_req  in  1  data-hazard stall request from the ID-stage hazard detector.
REQ-006 Port i_branch_taken  in  1  taken branch/JAL/JALR resolved in EX; PC target valid this cycle.
REQ-007 Port i_mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-008 Port o_pc_we  out  1  PC register write enable.
REQ-009 Port o_if_id_we  out  1  IF/ID pipeline register write enable.
REQ-010 Port o_if_id_flush  out  1  load NOP into IF/ID.
REQ-011 Port o_id_ex_bubble  out  1  load NOP into ID/EX.
REQ-012 Port o_ex_mem_we  out  1  EX/MEM write enable.
REQ-013 Port o_mem_wb_we  out  1  MEM/WB write enable.
REQ-014 Port o_state  out  2  current FSM state encoding.
REQ-015 Port o_timeout  out  1  sticky watchdog flag.

Function
REQ-016 FSM states SHALL be RUN=0, HAZ=1, FLUSH=2, MEMW=3; state and counters registered, outputs combinational from state and current inputs.
REQ-017 Input priority SHALL be i_mem_busy > i_branch_taken > i_stall_req in every state.
REQ-018 RUN with no request: all four write enables 1, flush 0, bubble 0.
REQ-019 i_mem_busy=1 in any state: o_pc_we, o_if_id_we, o_ex_mem_we, o_mem_wb_we all 0, flush 0, bubble 0; next state MEMW; prior state and flush count saved on MEMW entry, not overwritten while in MEMW.
REQ-020 MEMW with i_mem_busy=0: outputs per the saved state with the current inputs, and next state derived from the saved state, as if MEMW never occurred; frozen counters resume unchanged.
REQ-021 i_branch_taken=1 in RUN or HAZ (no mem busy): o_pc_we=1, o_if_id_we=1, o_if_id_flush=1, o_id_ex_bubble=1, EX/MEM and MEM/WB we=1; if FLUSH_LEN>1 next state FLUSH with counter=FLUSH_LEN-1, else RUN.
REQ-022 FLUSH: o_pc_we=1, o_if_id_flush=1, o_id_ex_bubble=0, others we=1; counter decrements per non-frozen cycle; exit to RUN when counter reaches 1 at a clock edge; i_stall_req ignored; i_branch_taken in FLUSH reloads counter to FLUSH_LEN-1.
REQ-023 i_stall_req=1 in RUN or HAZ (no branch, no busy): o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=1, EX/MEM and MEM/WB we=1; next state HAZ.
REQ-024 HAZ with i_stall_req=0: RUN outputs this cycle, next state RUN, stall counter cleared.
REQ-025 8-bit stall counter SHALL increment each HAZ-stall cycle, saturate at 255, clear on leaving HAZ (not on MEMW); o_timeout set when counter reaches WDOG_MAX and held until reset.

Reset
REQ-026 With i_rst_n=0 at a rising edge: state RUN, all counters 0, o_timeout 0, saved state RUN.
REQ-027 While i_rst_n=0: o_pc_we=0, o_if_id_we=0, o_if_id_flush=1, o_id_ex_bubble=1, o_ex_mem_we=0, o_mem_wb_we=0, inputs ignored; reset mid-flush or mid-MEMW SHALL abandon that operation.

Configuration
REQ-028 Macro STALL_PERF_CNT_EN defined: extra output o_stall_cycles (out, 32) counting every cycle with o_pc_we=0 while i_rst_n=1, wrapping at 2^32, cleared by reset.
REQ-029 Macro undefined: port o_stall_cycles and its counter absent; all other behaviour identical.

Verification
REQ-030 Reset then idle: i_rst_n 0->1 with no requests -> next cycle o_state=0, all we=1, flush=0, bubble=0.
REQ-031 i_stall_req high 3 cycles -> 3 cycles o_pc_we=0, o_if_id_we=0, bubble=1, o_state=1; 4th cycle RUN outputs.
REQ-032 i_branch_taken 1 cycle, FLUSH_LEN=2 -> cycle0 flush=1 and bubble=1; cycle1 o_state=2, flush=1, bubble=0; cycle2 RUN; concurrent i_stall_req in cycle1 ignored.
REQ-033 FLUSH entered then i_mem_busy 4 cycles -> all we=0 for 4 cycles, o_state=3; after release exactly one FLUSH cycle remains.
REQ-034 WDOG_MAX=10, i_stall_req held 12 cycles -> o_timeout=1 after 10th stall edge, remains 1 after i_stall_req drops, cleared only by reset.
REQ-035 STALL_PERF_CNT_EN defined, 3 hazard + 4 mem-busy cycles -> o_stall_cycles=7.

Source files
------------

// File: rtl/stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : stall_controller
// Brief    : Pipeline hazard/branch/memory-wait controller with a hazard watchdog.
//            Optional macro STALL_PERF_CNT_EN adds the o_stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module stall_controller #(
    parameter int FLUSH_LEN = 2,
    parameter int WDOG_MAX  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_req,
    input  logic        i_branch_taken,
    input  logic        i_mem_busy,
    output logic        o_pc_we,
    output logic        o_if_id_we,
    output logic        o_if_id_flush,
    output logic        o_id_ex_bubble,
    output logic        o_ex_mem_we,
    output logic        o_mem_wb_we,
    output logic [1:0]  o_state,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0] o_stall_cycles,
`endif
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEMW  = 2'd3
    } state_t;

    localparam logic [3:0] c_flush_reload = 4'(FLUSH_LEN - 1);
    localparam logic [7:0] c_wdog_max     = 8'(WDOG_MAX);
    localparam bit         c_has_flush    = (FLUSH_LEN > 1);

    state_t     r_state;
    state_t     r_saved_state;
    logic [3:0] r_flush_cnt;
    logic [7:0] r_stall_cnt;
    logic       r_timeout;

    state_t     w_eff_state;
    logic [7:0] w_stall_inc;

    // After a memory wait the controller behaves as if it were still in the saved state.
    assign w_eff_state = (r_state == ST_MEMW) ? r_saved_state : r_state;
    assign w_stall_inc = (r_stall_cnt == 8'hFF) ? 8'hFF : r_stall_cnt + 8'd1;

    assign o_state   = r_state;
    assign o_timeout = r_timeout;

    always_comb begin
        o_pc_we        = 1'b1;
        o_if_id_we     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_we    = 1'b1;
        o_mem_wb_we    = 1'b1;
        if (!i_rst_n) begin
            o_pc_we        = 1'b0;
            o_if_id_we     = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_we    = 1'b0;
            o_mem_wb_we    = 1'b0;
        end else if (i_mem_busy) begin
            o_pc_we     = 1'b0;
            o_if_id_we  = 1'b0;
            o_ex_mem_we = 1'b0;
            o_mem_wb_we = 1'b0;
        end else if (w_eff_state == ST_FLUSH) begin
            o_if_id_flush = 1'b1;
        end else if (i_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else if (i_stall_req) begin
            o_pc_we        = 1'b0;
            o_if_id_we     = 1'b0;
            o_id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_saved_state <= ST_RUN;
            r_flush_cnt   <= 4'd0;
            r_stall_cnt   <= 8'd0;
            r_timeout     <= 1'b0;
        end else if (i_mem_busy) begin
            // Capture only on entry so a long wait keeps the original context.
            if (r_state != ST_MEMW) begin
                r_saved_state <= r_state;
                r_state       <= ST_MEMW;
            end
        end else begin
            case (w_eff_state)
                ST_FLUSH: begin
                    r_stall_cnt <= 8'd0;
                    if (i_branch_taken) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= c_flush_reload;
                    end else if (r_flush_cnt <= 4'd1) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= 4'd0;
                    end else begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    if (i_branch_taken) begin
                        r_stall_cnt <= 8'd0;
                        if (c_has_flush) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= c_flush_reload;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (i_stall_req) begin
                        r_state     <= ST_HAZ;
                        r_stall_cnt <= w_stall_inc;
                        if (w_stall_inc >= c_wdog_max) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_state     <= ST_RUN;
                        r_stall_cnt <= 8'd0;
                    end
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (!o_pc_we) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall_controller
// Brief    : Self-checking bench: directed literal checks plus random stimulus
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stall_controller;

    localparam int FLUSH_LEN = 2;
    localparam int WDOG_MAX  = 10;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall_req;
    logic        i_branch_taken;
    logic        i_mem_busy;
    logic        o_pc_we;
    logic        o_if_id_we;
    logic        o_if_id_flush;
    logic        o_id_ex_bubble;
    logic        o_ex_mem_we;
    logic        o_mem_wb_we;
    logic [1:0]  o_state;
    logic        o_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] o_stall_cycles;
`endif

    stall_controller #(
        .FLUSH_LEN (FLUSH_LEN),
        .WDOG_MAX  (WDOG_MAX)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_stall_req    (i_stall_req),
        .i_branch_taken (i_branch_taken),
        .i_mem_busy     (i_mem_busy),
        .o_pc_we        (o_pc_we),
        .o_if_id_we     (o_if_id_we),
        .o_if_id_flush  (o_if_id_flush),
        .o_id_ex_bubble (o_id_ex_bubble),
        .o_ex_mem_we    (o_ex_mem_we),
        .o_mem_wb_we    (o_mem_wb_we),
        .o_state        (o_state),
`ifdef STALL_PERF_CNT_EN
        .o_stall_cycles (o_stall_cycles),
`endif
        .o_timeout      (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining flush cycles, hazard flag, memory-hold flag, stall streak.
    bit          m_valid     = 1'b0;
    int          m_flush_left = 0;
    bit          m_haz       = 1'b0;
    bit          m_held      = 1'b0;
    int          m_streak    = 0;
    bit          m_to        = 1'b0;
    logic [31:0] m_perf      = 32'd0;

    // Order: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we}
    function automatic logic [5:0] exp_out(input logic rst_n, input logic stall,
                                           input logic br, input logic busy);
        if (!rst_n)           return 6'b001100;
        if (busy)             return 6'b000000;
        if (m_flush_left > 0) return 6'b111011;
        if (br)               return 6'b111111;
        if (stall)            return 6'b000111;
        return 6'b110011;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_held)           return 2'd3;
        if (m_flush_left > 0) return 2'd2;
        if (m_haz)            return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge i_clk) begin
        logic [5:0] e;
        e = exp_out(i_rst_n, i_stall_req, i_branch_taken, i_mem_busy);
        if (!i_rst_n) begin
            m_valid      = 1'b1;
            m_flush_left = 0;
            m_haz        = 1'b0;
            m_held       = 1'b0;
            m_streak     = 0;
            m_to         = 1'b0;
            m_perf       = 32'd0;
        end else begin
            if (!e[5]) m_perf = m_perf + 32'd1;
            if (i_mem_busy) begin
                m_held = 1'b1;
            end else begin
                m_held = 1'b0;
                if (m_flush_left > 0) begin
                    m_flush_left = i_branch_taken ? FLUSH_LEN - 1 : m_flush_left - 1;
                    m_streak = 0;
                end else if (i_branch_taken) begin
                    m_flush_left = FLUSH_LEN - 1;
                    m_haz = 1'b0;
                    m_streak = 0;
                end else if (i_stall_req) begin
                    m_haz = 1'b1;
                    m_streak = (m_streak >= 255) ? 255 : m_streak + 1;
                    if (m_streak >= WDOG_MAX) m_to = 1'b1;
                end else begin
                    m_haz = 1'b0;
                    m_streak = 0;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        logic [5:0] e;
        if (m_valid) begin
            e = exp_out(i_rst_n, i_stall_req, i_branch_taken, i_mem_busy);
            chk("pc_we",     32'(o_pc_we),        32'(e[5]));
            chk("if_id_we",  32'(o_if_id_we),     32'(e[4]));
            chk("flush",     32'(o_if_id_flush),  32'(e[3]));
            chk("bubble",    32'(o_id_ex_bubble), 32'(e[2]));
            chk("ex_mem_we", 32'(o_ex_mem_we),    32'(e[1]));
            chk("mem_wb_we", 32'(o_mem_wb_we),    32'(e[0]));
            chk("state",     32'(o_state),        32'(exp_state()));
            chk("timeout",   32'(o_timeout),      32'(m_to));
`ifdef STALL_PERF_CNT_EN
            chk("stall_cycles", o_stall_cycles, m_perf);
`endif
        end
    end

    task automatic cyc(input logic r, input logic s, input logic b, input logic m);
        @(posedge i_clk);
        #1;
        i_rst_n        = r;
        i_stall_req    = s;
        i_branch_taken = b;
        i_mem_busy     = m;
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        int heavy;
        i_rst_n = 1'b0; i_stall_req = 1'b1; i_branch_taken = 1'b1; i_mem_busy = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #1;
        chk("rst_pc_we",   32'(o_pc_we),        32'd0);
        chk("rst_flush",   32'(o_if_id_flush),  32'd1);
        chk("rst_bubble",  32'(o_id_ex_bubble), 32'd1);
        chk("rst_state",   32'(o_state),        32'd0);
        chk("rst_timeout", 32'(o_timeout),      32'd0);

        cyc(1, 0, 0, 0);
        chk("idle_state", 32'(o_state), 32'd0);
        chk("idle_pc_we", 32'(o_pc_we), 32'd1);
        chk("idle_mem_wb_we", 32'(o_mem_wb_we), 32'd1);
        chk("idle_flush", 32'(o_if_id_flush), 32'd0);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0);
            chk("haz_pc_we", 32'(o_pc_we), 32'd0);
            chk("haz_if_id_we", 32'(o_if_id_we), 32'd0);
            chk("haz_bubble", 32'(o_id_ex_bubble), 32'd1);
            if (i > 0) chk("haz_state", 32'(o_state), 32'd1);
        end
        cyc(1, 0, 0, 0);
        chk("haz_exit_pc_we", 32'(o_pc_we), 32'd1);
        chk("haz_exit_bubble", 32'(o_id_ex_bubble), 32'd0);

        cyc(1, 0, 1, 0);
        chk("br0_flush", 32'(o_if_id_flush), 32'd1);
        chk("br0_bubble", 32'(o_id_ex_bubble), 32'd1);
        cyc(1, 1, 0, 0);
        chk("br1_state", 32'(o_state), 32'd2);
        chk("br1_flush", 32'(o_if_id_flush), 32'd1);
        chk("br1_bubble", 32'(o_id_ex_bubble), 32'd0);
        chk("br1_pc_we", 32'(o_pc_we), 32'd1);
        cyc(1, 0, 0, 0);
        chk("br2_state", 32'(o_state), 32'd0);
        chk("br2_flush", 32'(o_if_id_flush), 32'd0);

        cyc(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1);
            chk("memw_pc_we", 32'(o_pc_we), 32'd0);
            chk("memw_mem_wb_we", 32'(o_mem_wb_we), 32'd0);
            if (i > 0) chk("memw_state", 32'(o_state), 32'd3);
        end
        cyc(1, 0, 0, 0);
        chk("memw_rel_flush", 32'(o_if_id_flush), 32'd1);
        chk("memw_rel_pc_we", 32'(o_pc_we), 32'd1);
        cyc(1, 0, 0, 0);
        chk("memw_done_state", 32'(o_state), 32'd0);
        chk("memw_done_flush", 32'(o_if_id_flush), 32'd0);

        for (int i = 1; i <= 12; i++) begin
            cyc(1, 1, 0, 0);
            chk("wdog_timeout", 32'(o_timeout), (i <= 10) ? 32'd0 : 32'd1);
        end
        cyc(1, 0, 0, 0);
        chk("wdog_sticky", 32'(o_timeout), 32'd1);
        cyc(1, 0, 0, 0);
        chk("wdog_sticky2", 32'(o_timeout), 32'd1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("wdog_cleared", 32'(o_timeout), 32'd0);

        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("perf_seven", o_stall_cycles, 32'd7);
`endif
        chk("perf_seq_pc_we", 32'(o_pc_we), 32'd1);

        heavy = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, s, b, m;
            if (n % 250 == 0) heavy = $urandom_range(0, 1);
            r = ($urandom_range(0, 199) != 0);
            if (heavy != 0) begin
                s = ($urandom_range(0, 99) < 92);
                b = ($urandom_range(0, 99) < 2);
                m = ($urandom_range(0, 99) < 10);
            end else begin
                s = ($urandom_range(0, 99) < 45);
                b = ($urandom_range(0, 99) < 15);
                m = ($urandom_range(0, 99) < 15);
            end
            cyc(r, s, b, m);
        end

        @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
